ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain ps2c/ps2d lines. It performs the request-to-send inhibit, shifts 8 data bits plus odd parity on device-generated clock edges, releases the line for the stop bit, and returns the bus to idle. Its `tx_idle` output gates the receive enable of the keyboard receiver, so the two blocks never own the bus at the same time.

## Interface
- `INHIBIT_CYCLES`, default 5000: clk cycles ps2c is held low for request-to-send (100 µs at 50 MHz).
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `wr_ps2` input, 1 bit: single-cycle start request, sampled only in `idle`.
- `din` input, 8 bits: command byte, captured on the accepted `wr_ps2` cycle.
- `ps2c_in` input, 1 bit: raw PS/2 clock pad value.
- `ps2d_in` input, 1 bit: raw PS/2 data pad value.
- `ps2c_oe` output, 1 bit: 1 drives the ps2c pad low; 0 releases it (pulled high).
- `ps2d_oe` output, 1 bit: 1 drives the ps2d pad low; 0 releases it.
- `tx_idle` output, 1 bit: 1 only in state `idle`; connects to the receiver's `rx_en`.
- `tx_done_tick` output, 1 bit: one-cycle pulse when a frame completes.
- `ack_err` output, 1 bit: sticky flag, set when the device did not acknowledge; cleared on the next accepted `wr_ps2`.

## Operation
- ps2c filter, identical to the receiver's filter:
  - 8-bit shift register of `ps2c_in`.
  - The filtered clock goes 1 only when the register is all 1s, and 0 only when it is all 0s; otherwise it holds.
  - `fall_edge` = filtered clock is 1 now and its next value is 0.
- Frame register `b_reg[8:0]` = {odd parity, din}, with parity = ~^din. Counter `n_reg[3:0]`; inhibit counter sized to hold `INHIBIT_CYCLES`.
- State `idle`: both oe = 0.
  - `wr_ps2`=1: load `b_reg`, clear the inhibit counter and `ack_err`, go to `rts`.
- State `rts`: `ps2c_oe`=1, `ps2d_oe`=1.
  - Count to `INHIBIT_CYCLES`-1, then go to `start`.
- State `start`: `ps2c_oe`=0, `ps2d_oe`=1 (start bit 0).
  - On `fall_edge`: set `n_reg`=8, go to `data`.
- State `data`: `ps2d_oe` = ~`b_reg[0]`.
  - On `fall_edge`: shift `b_reg` right.
  - If `n_reg`==0, go to `stop`; else decrement `n_reg`.
- State `stop`: `ps2d_oe`=0 (stop bit 1).
  - On `fall_edge`: go to `ack` (macro on) or `done` (macro off).
- State `ack`: both oe = 0.
  - On `fall_edge`: set `ack_err` = `ps2d_in` (device drives 0 for ACK), then go to `done`.
- State `done`: `tx_done_tick`=1 for one cycle, then go to `idle`.
- `wr_ps2` outside `idle` is ignored; `din` changes after capture have no effect.
- `ps2d_in` is used only in `ack`. The data pad is never driven high.

## Timing
- Reset values: state `idle`, `ps2c_oe`=0, `ps2d_oe`=0, `tx_idle`=1, `tx_done_tick`=0, `ack_err`=0, filter register 0, filtered clock 0.
- `ps2c_oe`/`ps2d_oe` are decoded from the state register.
  - `wr_ps2` high in cycle 0 → both oe = 1 from cycle 1.
  - `ps2c_oe` stays high for exactly `INHIBIT_CYCLES` cycles.
- Each bit change occurs in the cycle after the filtered falling edge. The filter delays edges by at most 8 cycles, well inside the ≥30 µs device low-phase.
- `tx_idle` falls in cycle 1 and rises the cycle after `tx_done_tick`. The receiver therefore ignores the host's own frame and the ACK bit.
- Frame = start + 8 data (LSB first) + parity + stop: the device supplies 11 falling edges, plus 1 ACK edge with the macro on.
- Reset asserted mid-frame: both oe drop to 0 immediately (asynchronously), the frame is abandoned, and no `tx_done_tick` is produced.
- No timeout is implemented. A silent device leaves the block in `start`/`data` until reset.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined:
  - The `ack` state is present; one extra falling edge is consumed after stop.
  - `ack_err` reflects `ps2d_in` sampled on that edge.
- Not defined:
  - `stop` goes directly to `done`.
  - `ack_err` is tied to 0.
  - The device's ACK edge occurs after `tx_idle` has returned to 1 and is left to the receiver, which discards it as an incomplete frame.

## Test plan
- Inhibit: `INHIBIT_CYCLES`=50, `wr_ps2` with `din`=0xED → `ps2c_oe`=1 for exactly 50 cycles with `ps2d_oe`=1; then `ps2c_oe`=0 and `ps2d_oe`=1.
- Frame content: `din`=0xED; the device model samples on each rising edge → bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; then `tx_done_tick` pulses once and `tx_idle`=1.
- Parity: `din`=0x07 → parity bit 0; `din`=0x00 → parity bit 1.
- Busy lockout: second `wr_ps2` with `din`=0xFF during `data` → ignored; the frame still carries 0xED and only one `tx_done_tick` is produced.
- Reset mid-frame: assert `reset` after the 4th falling edge → both oe = 0 within the same cycle; `tx_idle`=1; the next `wr_ps2` sends a full, correct frame.
- ACK (`PS2_TX_ACK_CHECK_EN`): device drives ps2d low on the 12th edge → `ack_err`=0; device leaves ps2d high → `ack_err`=1, held until the next `wr_ps2`.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send inhibit, start bit, 8 data
// bits LSB first, odd parity, stop bit, then return to idle.
// Optional build macro PS2_TX_ACK_CHECK_EN adds the device ACK bit check;
// without it ack_err is tied to 0 and the ACK edge is left to the receiver.
//
// state   | meaning
// --------+-------------------------------------------------------------
// idle    | bus released, waiting for wr_ps2
// rts     | ps2c and ps2d held low for INHIBIT_CYCLES (request-to-send)
// start   | ps2c released, ps2d low (start bit) until first device edge
// data    | 8 data bits + parity shifted out on device falling edges
// stop    | ps2d released (stop bit 1)
// ack     | bus released, device ACK sampled on the next falling edge
// done    | one-cycle completion pulse
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      filt_q, filt_d;
    logic            f_ps2c_q, f_ps2c_d;
    logic [8:0]      b_q, b_d;
    logic [3:0]      n_q, n_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ack_err_q, ack_err_d;
    logic            fall_edge;

    // Glitch filter on the device clock: output only moves on 8 agreeing samples.
    always_comb begin
        filt_d   = {ps2c_in, filt_q[7:1]};
        f_ps2c_d = f_ps2c_q;
        if (filt_q == 8'hFF) begin
            f_ps2c_d = 1'b1;
        end else if (filt_q == 8'h00) begin
            f_ps2c_d = 1'b0;
        end
    end

    assign fall_edge = f_ps2c_q & ~f_ps2c_d;

    // State register and datapath flops, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            filt_q    <= 8'h00;
            f_ps2c_q  <= 1'b0;
            b_q       <= 9'h000;
            n_q       <= 4'h0;
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            f_ps2c_q  <= f_ps2c_d;
            b_q       <= b_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Next-state and datapath updates; bits advance only on filtered falling edges.
    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        ack_err_d = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ps2) begin
                    b_d       = {~^din, din};
                    cnt_d     = '0;
                    ack_err_d = 1'b0;
                    state_d   = ST_RTS;
                end
            end
            ST_RTS: begin
                if (cnt_q == INH_LAST) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_START: begin
                if (fall_edge) begin
                    n_d     = 4'd8;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    b_d = {1'b0, b_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        n_d = n_q - 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    state_d = ST_ACK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_ACK: begin
`ifdef PS2_TX_ACK_CHECK_EN
                // Device pulls ps2d low to acknowledge; high means no ACK.
                if (fall_edge) begin
                    ack_err_d = ps2d_in;
                    state_d   = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pad enables decoded straight from the state register so reset releases the bus at once.
    always_comb begin
        ps2c_oe      = 1'b0;
        ps2d_oe      = 1'b0;
        tx_idle      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            ST_IDLE: tx_idle = 1'b1;
            ST_RTS: begin
                ps2c_oe = 1'b1;
                ps2d_oe = 1'b1;
            end
            ST_START: ps2d_oe = 1'b1;
            ST_DATA:  ps2d_oe = ~b_q[0];
            ST_DONE:  tx_done_tick = 1'b1;
            default: begin
                ps2c_oe = 1'b0;
                ps2d_oe = 1'b0;
            end
        endcase
    end

`ifdef PS2_TX_ACK_CHECK_EN
    assign ack_err = ack_err_q;
`else
    // ps2d_in has no reader without the ACK check.
    logic unused_ps2d;
    assign unused_ps2d = ps2d_in;
    assign ack_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and
// records the bits; a scoreboard monitor compares them on every tx_done_tick.
module tb_ps2_host_tx;

    localparam int INH = 50;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam int  N_EDGES = 12;
    localparam logic ACK_MODE = 1'b1;
`else
    localparam int  N_EDGES = 11;
    localparam logic ACK_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err;

    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic [10:0] cap_frame = '0;
    logic [10:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH)) dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every completion pops one expected frame.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=%0h required=none", cap_frame);
                end else begin
                    e = exp_q.pop_front();
                    if (cap_frame !== e) begin
                        errors++;
                        $display("FAIL frame actual=%03h required=%03h", cap_frame, e);
                    end
                end
                @(negedge clk);
                chk("idle_after_done", {30'd0, tx_idle, tx_done_tick}, 32'd2);
            end
        end
    end

    // Issue a start request; when a completion is expected, queue {stop, parity, din, start}.
    task automatic start_tx(input logic [7:0] d, input logic par, input logic expect_done);
        @(negedge clk);
        din    = d;
        wr_ps2 = 1'b1;
        if (expect_done) exp_q.push_back({1'b1, par, d, 1'b0});
        @(negedge clk);
        wr_ps2 = 1'b0;
        chk("tx_idle_low", {31'd0, tx_idle}, 32'd0);
        chk("ack_err_cleared", {31'd0, ack_err}, 32'd0);
    endtask

    // Device model: measures the inhibit, then generates clock edges and samples
    // ps2d on each rising edge (start bit sampled before the first edge).
    task automatic device_run(input int abort_at, input int poke_at, input logic ack_low);
        int  cnt;
        logic bad;
        cnt = 0;
        bad = 1'b0;
        cap_frame = '0;
        while (ps2c_oe && cnt < 1000) begin
            if (!ps2d_oe) bad = 1'b1;
            cnt++;
            @(negedge clk);
        end
        chk("inhibit_len", cnt, INH);
        chk("inhibit_d_low", {31'd0, bad}, 32'd0);
        chk("start_bit_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd1);
        repeat (20) @(negedge clk);
        cap_frame[0] = dev_d & ~ps2d_oe;
        for (int k = 1; k <= N_EDGES; k++) begin
            dev_c = 1'b0;
            repeat (12) @(negedge clk);
            if (k == abort_at) begin
                #3 reset = 1'b1;
                #1;
                chk("abort_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
                chk("abort_idle", {31'd0, tx_idle}, 32'd1);
                repeat (3) @(negedge clk);
                dev_c = 1'b1;
                reset = 1'b0;
                repeat (20) @(negedge clk);
                return;
            end
            if (k == poke_at) begin
                din    = 8'hFF;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (7) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            dev_c = 1'b1;
            if (k <= 10) cap_frame[k] = dev_d & ~ps2d_oe;
            if (k == 11 && ACK_MODE) dev_d = ack_low ? 1'b0 : 1'b1;
            repeat (20) @(negedge clk);
        end
        dev_d = 1'b1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!tx_idle && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("return_idle_timeout", g < 100 ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2;
        chk("rst_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        chk("rst_idle", {31'd0, tx_idle}, 32'd1);
        chk("rst_done", {31'd0, tx_done_tick}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);

        // 0xED: six ones, parity 1; ACK given
        start_tx(8'hED, 1'b1, 1'b1);
        device_run(0, 0, 1'b1);
        wait_idle();
        chk("ack_ok", {31'd0, ack_err}, 32'd0);

        // 0x07: three ones, parity 0
        start_tx(8'h07, 1'b0, 1'b1);
        device_run(0, 0, 1'b1);
        wait_idle();

        // 0x00: parity 1; device withholds ACK
        start_tx(8'h00, 1'b1, 1'b1);
        device_run(0, 0, 1'b0);
        wait_idle();
        chk("nack_err", {31'd0, ack_err}, {31'd0, ACK_MODE});
        repeat (30) @(negedge clk);
        chk("nack_sticky", {31'd0, ack_err}, {31'd0, ACK_MODE});

        // Busy lockout: 0xFF request during data must be ignored
        start_tx(8'hED, 1'b1, 1'b1);
        device_run(0, 5, 1'b1);
        wait_idle();
        repeat (20) @(negedge clk);
        chk("lockout_stays_idle", {31'd0, tx_idle}, 32'd1);

        // Reset after the 4th falling edge: frame abandoned, no completion
        start_tx(8'hA5, 1'b0, 1'b0);
        device_run(4, 0, 1'b1);
        chk("post_abort_idle", {31'd0, tx_idle}, 32'd1);

        // Full frame after the abort
        start_tx(8'hED, 1'b1, 1'b1);
        device_run(0, 0, 1'b1);
        wait_idle();

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
